// File: rtl/gated_release_multi.sv
// Multi-channel secret-gating benchmark.
// Two flow classes run side by side on every channel:
//   - a zero-latency gated path (secret -> out_comb) that leaks whenever
//     enable and the channel's visible bit are both high;
//   - a registered path (secret -> guard pipeline -> out_seq) that only
//     becomes observable if the phase counters can line up the capture
//     phase with the observation window DEPTH cycles later.
// prev is a shadow of state that always trails it by one (mod 2^STATE_W).
// It is reset to all ones so that the relation already holds out of reset.
//
// phase                 | meaning
// ----------------------+---------------------------------------------------
// state == RELEASE_STATE| guard stage 0 loads the secret on the next edge
// state != RELEASE_STATE| guard stage 0 loads zero on the next edge
// prev  == OBSERVE_PREV | window open: last guard stage drives out_seq
// prev  != OBSERVE_PREV | window closed: out_seq forced to zero
module gated_release_multi #(
  parameter int WIDTH         = 32,
  parameter int CHANNELS      = 4,
  parameter int STATE_W       = 2,
  parameter int RELEASE_STATE = 3,
  parameter int OBSERVE_PREV  = 1,
  parameter int DEPTH         = 1,
  parameter int CNT_W         = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       visible,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] secret,
  output logic [CHANNELS*WIDTH-1:0] out_comb,
  output logic [CHANNELS*WIDTH-1:0] out_seq,
  output logic [STATE_W-1:0]        state,
  output logic [STATE_W-1:0]        prev,
  output logic                      window,
  output logic [CNT_W-1:0]          leak_cnt
);

  localparam logic [STATE_W-1:0] REL_STATE = STATE_W'(RELEASE_STATE);
  localparam logic [STATE_W-1:0] OBS_PREV  = STATE_W'(OBSERVE_PREV);
  // All ones is state-1 for state == 0, which keeps the shadow aligned.
  localparam logic [STATE_W-1:0] PREV_RST  = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic             release_hit;
  logic             any_leak;
  logic [WIDTH-1:0] guard_q [CHANNELS][DEPTH];

  // Phase counter and its shadow advance together so they can never drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      prev  <= PREV_RST;
    end else if (enable) begin
      state <= state + 1'b1;
      prev  <= prev + 1'b1;
    end
  end

  // Phase decodes for capture and observation.
  always_comb begin
    release_hit = (state == REL_STATE);
    window      = (prev == OBS_PREV);
  end

  // Guard pipeline: flush beats capture; capture ignores enable on purpose so
  // a held phase keeps re-sampling the secret.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          guard_q[c][k] <= '0;
        end
      end
    end else if (flush) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          guard_q[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        guard_q[c][0] <= release_hit ? secret[c*WIDTH +: WIDTH] : '0;
        for (int k = 1; k < DEPTH; k++) begin
          guard_q[c][k] <= guard_q[c][k-1];
        end
      end
    end
  end

  // Per-channel output gating for both flow classes.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign out_comb[c*WIDTH +: WIDTH] =
      (enable && visible[c]) ? secret[c*WIDTH +: WIDTH] : '0;
    assign out_seq[c*WIDTH +: WIDTH] =
      window ? guard_q[c][DEPTH-1] : '0;
  end

  // Any nonzero registered output counts as one leak event for the cycle.
  always_comb begin
    any_leak = |out_seq;
  end

  // Saturating leak-event counter; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leak_cnt <= '0;
    end else if (any_leak && (leak_cnt != CNT_MAX)) begin
      leak_cnt <= leak_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gated_release_multi.sv
// Bench for gated_release_multi: three instances share one stimulus stream.
//   inst 0: defaults (release 3, observe 1, depth 1, 8-bit counter)
//   inst 1: observe 3, depth 1
//   inst 2: observe 0, depth 2, 2-bit counter
module tb_gated_release_multi;
  localparam int W  = 32;
  localparam int CH = 4;
  localparam int NI = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           flush = 1'b0;
  logic [CH-1:0]  visible = '0;
  logic [CH*W-1:0] secret = '0;

  logic [CH*W-1:0] oc [NI];
  logic [CH*W-1:0] os [NI];
  logic [1:0]      st [NI];
  logic [1:0]      pv [NI];
  logic            win [NI];
  logic [7:0]      lc0, lc1;
  logic [1:0]      lc2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gated_release_multi u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .visible(visible), .flush(flush),
    .secret(secret), .out_comb(oc[0]), .out_seq(os[0]), .state(st[0]),
    .prev(pv[0]), .window(win[0]), .leak_cnt(lc0));

  gated_release_multi #(.OBSERVE_PREV(3), .DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .visible(visible), .flush(flush),
    .secret(secret), .out_comb(oc[1]), .out_seq(os[1]), .state(st[1]),
    .prev(pv[1]), .window(win[1]), .leak_cnt(lc1));

  gated_release_multi #(.OBSERVE_PREV(0), .DEPTH(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .visible(visible), .flush(flush),
    .secret(secret), .out_comb(oc[2]), .out_seq(os[2]), .state(st[2]),
    .prev(pv[2]), .window(win[2]), .leak_cnt(lc2));

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [1:0]  st;
    logic [1:0]  pv;
    logic [127:0] os;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];

  logic [1:0]  m_st [NI];
  logic [1:0]  m_pv [NI];
  logic [31:0] m_g  [NI][CH][2];
  logic [7:0]  m_cnt [NI];

  function automatic int obs_of(int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int dep_of(int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic [7:0] cmax_of(int i);
    return (i == 2) ? 8'd3 : 8'd255;
  endfunction

  function automatic logic [7:0] dut_cnt(int i);
    case (i)
      0: return lc0;
      1: return lc1;
      default: return {6'b0, lc2};
    endcase
  endfunction

  function automatic logic [127:0] m_oseq(int i);
    logic [127:0] r;
    r = '0;
    if (m_pv[i] == 2'(obs_of(i))) begin
      for (int c = 0; c < CH; c++) r[c*W +: W] = m_g[i][c][dep_of(i)-1];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 2'd0;
      m_pv[i] = 2'd3;
      m_cnt[i] = 8'd0;
      for (int c = 0; c < CH; c++) begin
        m_g[i][c][0] = '0;
        m_g[i][c][1] = '0;
      end
    end
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_tick();
    for (int i = 0; i < NI; i++) begin
      logic leak;
      leak = (m_oseq(i) != '0);
      if (leak && (m_cnt[i] < cmax_of(i))) m_cnt[i] = m_cnt[i] + 8'd1;
      for (int c = 0; c < CH; c++) begin
        if (flush) begin
          m_g[i][c][0] = '0;
          m_g[i][c][1] = '0;
        end else begin
          for (int k = dep_of(i) - 1; k >= 1; k--) m_g[i][c][k] = m_g[i][c][k-1];
          m_g[i][c][0] = (m_st[i] == 2'd3) ? secret[c*W +: W] : '0;
        end
      end
      if (enable) begin
        m_st[i] = m_st[i] + 2'd1;
        m_pv[i] = m_pv[i] + 2'd1;
      end
    end
  endtask

  // One clock: push expectations, take the edge, pop and compare.
  task automatic cycle();
    exp_t e;
    model_tick();
    for (int i = 0; i < NI; i++) begin
      e.id = i; e.st = m_st[i]; e.pv = m_pv[i]; e.os = m_oseq(i); e.cnt = m_cnt[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (st[e.id] !== e.st) begin
        n_bad++; $display("FAIL state[%0d] got %h exp %h", e.id, st[e.id], e.st);
      end
      n_vec++;
      if (pv[e.id] !== e.pv) begin
        n_bad++; $display("FAIL prev[%0d] got %h exp %h", e.id, pv[e.id], e.pv);
      end
      n_vec++;
      if (pv[e.id] !== 2'(st[e.id] - 2'd1)) begin
        n_bad++; $display("FAIL invariant[%0d] prev %h state %h", e.id, pv[e.id], st[e.id]);
      end
      n_vec++;
      if (os[e.id] !== e.os) begin
        n_bad++; $display("FAIL out_seq[%0d] got %h exp %h", e.id, os[e.id], e.os);
      end
      n_vec++;
      if (dut_cnt(e.id) !== e.cnt) begin
        n_bad++; $display("FAIL leak_cnt[%0d] got %0d exp %0d", e.id, dut_cnt(e.id), e.cnt);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < NI; i++) begin
      n_vec++;
      if (st[i] !== 2'd0) begin n_bad++; $display("FAIL rst_state[%0d] got %h exp 0", i, st[i]); end
      n_vec++;
      if (pv[i] !== 2'd3) begin n_bad++; $display("FAIL rst_prev[%0d] got %h exp 3", i, pv[i]); end
      n_vec++;
      if (os[i] !== '0) begin n_bad++; $display("FAIL rst_out_seq[%0d] got %h exp 0", i, os[i]); end
      n_vec++;
      if (dut_cnt(i) !== 8'd0) begin n_bad++; $display("FAIL rst_leak[%0d] got %0d exp 0", i, dut_cnt(i)); end
      n_vec++;
      if (win[i] !== (obs_of(i) == 3)) begin
        n_bad++; $display("FAIL rst_window[%0d] got %b exp %b", i, win[i], (obs_of(i) == 3));
      end
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_comb();
    logic [127:0] exp;
    secret  = {32'hCAFEF00D, 32'h0BADF00D, 32'h55AA55AA, 32'hDEADBEEF};
    enable  = 1'b1;
    visible = 4'b0001;
    #1;
    exp = {96'h0, 32'hDEADBEEF};
    n_vec++;
    if (oc[0] !== exp) begin n_bad++; $display("FAIL comb_ch0 got %h exp %h", oc[0], exp); end
    cycle();
    enable = 1'b0;
    #1;
    n_vec++;
    if (oc[0] !== '0) begin n_bad++; $display("FAIL comb_disabled got %h exp 0", oc[0]); end
    cycle();
    enable  = 1'b1;
    visible = 4'b1010;
    #1;
    exp = {32'hCAFEF00D, 32'h0, 32'h55AA55AA, 32'h0};
    n_vec++;
    if (oc[0] !== exp) begin n_bad++; $display("FAIL comb_ch13 got %h exp %h", oc[0], exp); end
    cycle();
  endtask

  task automatic test_random();
    logic [127:0] exp;
    flush = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      enable  = 1'($urandom_range(0, 1));
      visible = 4'($urandom);
      secret  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      exp = '0;
      for (int c = 0; c < CH; c++) if (enable && visible[c]) exp[c*W +: W] = secret[c*W +: W];
      n_vec++;
      if (oc[0] !== exp) begin n_bad++; $display("FAIL rand_comb got %h exp %h", oc[0], exp); end
      cycle();
      n_vec++;
      if (os[0] !== '0) begin n_bad++; $display("FAIL default_out_seq got %h exp 0", os[0]); end
      n_vec++;
      if (lc0 !== 8'd0) begin n_bad++; $display("FAIL default_leak got %0d exp 0", lc0); end
    end
  endtask

  task automatic test_obs3_leak();
    logic [127:0] leak_v;
    leak_v  = {32'h0, 32'h12345678, 64'h0};
    do_reset();
    enable  = 1'b1;
    visible = '0;
    flush   = 1'b0;
    secret  = leak_v;
    for (int n = 1; n <= 9; n++) begin
      cycle();
      if (n == 4) begin
        n_vec++;
        if (os[1] !== leak_v) begin n_bad++; $display("FAIL obs3_release got %h exp %h", os[1], leak_v); end
        n_vec++;
        if (lc1 !== 8'd0) begin n_bad++; $display("FAIL obs3_leak_pre got %0d exp 0", lc1); end
      end
      if (n == 5) begin
        n_vec++;
        if (lc1 !== 8'd1) begin n_bad++; $display("FAIL obs3_leak_1 got %0d exp 1", lc1); end
        n_vec++;
        if (os[2] !== leak_v) begin n_bad++; $display("FAIL depth2_latency got %h exp %h", os[2], leak_v); end
      end
      if (n == 9) begin
        n_vec++;
        if (lc1 !== 8'd2) begin n_bad++; $display("FAIL obs3_leak_2 got %0d exp 2", lc1); end
      end
    end
  endtask

  task automatic test_flush();
    cycle();
    cycle();
    flush = 1'b1;
    cycle();
    n_vec++;
    if (os[1] !== '0) begin n_bad++; $display("FAIL flush_out_seq got %h exp 0", os[1]); end
    n_vec++;
    if (lc1 !== 8'd2) begin n_bad++; $display("FAIL flush_leak got %0d exp 2", lc1); end
    flush = 1'b0;
    cycle();
    n_vec++;
    if (lc1 !== 8'd2) begin n_bad++; $display("FAIL flush_leak_after got %0d exp 2", lc1); end
    n_vec++;
    if (lc2 !== 2'd2) begin n_bad++; $display("FAIL flush_keeps_cnt got %0d exp 2", lc2); end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 12; n++) cycle();
    n_vec++;
    if (lc2 !== 2'd3) begin n_bad++; $display("FAIL saturate got %0d exp 3", lc2); end
  endtask

  task automatic test_enable_low();
    logic [127:0] last;
    for (int n = 0; n < 4 && m_st[0] != 2'd3; n++) cycle();
    enable = 1'b0;
    for (int n = 0; n < 3; n++) begin
      secret = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      n_vec++;
      if (st[1] !== 2'd3) begin n_bad++; $display("FAIL hold_state got %h exp 3", st[1]); end
    end
    last   = {32'h0, 32'hA5A50F0F, 64'h0};
    secret = last;
    enable = 1'b1;
    cycle();
    n_vec++;
    if (os[1] !== last) begin n_bad++; $display("FAIL recapture got %h exp %h", os[1], last); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (st[1] !== 2'd0) begin n_bad++; $display("FAIL mid_rst_state got %h exp 0", st[1]); end
    n_vec++;
    if (pv[1] !== 2'd3) begin n_bad++; $display("FAIL mid_rst_prev got %h exp 3", pv[1]); end
    n_vec++;
    if (os[1] !== '0) begin n_bad++; $display("FAIL mid_rst_out_seq got %h exp 0", os[1]); end
    n_vec++;
    if (lc1 !== 8'd0) begin n_bad++; $display("FAIL mid_rst_leak1 got %0d exp 0", lc1); end
    n_vec++;
    if (lc2 !== 2'd0) begin n_bad++; $display("FAIL mid_rst_leak2 got %0d exp 0", lc2); end
    model_reset();
    rst_n = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_comb();
    test_random();
    test_obs3_leak();
    test_flush();
    test_saturate();
    test_enable_low();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gated_release_multi.md
Name: gated_release_multi

Overview:
- Parametrised, multi-channel successor to the single-channel secret-gating test design.
- Demonstrates two flow classes side by side:
  - a combinational gated path, secret to out_comb, which can leak;
  - a registered, phase-guarded path, secret to guard pipeline to out_seq, which a phase-counter invariant makes reachable or unreachable depending on parameters.
- Serves as a scalable benchmark for the flow-analysis tools and as a verification target for invariant-dependent non-interference.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of independent secret channels.
- STATE_W, 2, width of the phase counter (wraps modulo 2^STATE_W).
- RELEASE_STATE, 3, state value on which the guard stage 0 captures the secret.
- OBSERVE_PREV, 1, prev value on which the last guard stage drives out_seq.
- DEPTH, 1, number of guard pipeline stages (>=1).
- CNT_W, 8, width of the saturating leak-event counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  advances phase counter; also gates the combinational path.
- visible  input  CHANNELS  per-channel combinational-path visibility.
- flush  input  1  synchronous clear of all guard stages.
- secret  input  CHANNELS*WIDTH  packed secrets; channel c occupies bits [c*WIDTH +: WIDTH].
- out_comb  output  CHANNELS*WIDTH  combinational gated outputs.
- out_seq  output  CHANNELS*WIDTH  registered, phase-guarded outputs.
- state  output  STATE_W  phase counter.
- prev  output  STATE_W  shadow counter.
- window  output  1  high when prev == OBSERVE_PREV.
- leak_cnt  output  CNT_W  saturating count of cycles with any nonzero out_seq channel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = 0, prev = all ones;
  - all guard stages = 0; leak_cnt = 0.
  - Consequently out_seq = 0 and window = (OBSERVE_PREV == all ones).
- Phase counters:
  - if enable, state <= state+1 and prev <= prev+1, both wrapping.
  - Invariant: prev == state-1 mod 2^STATE_W in every cycle, including immediately after reset. Verification asserts it.
- Combinational path, per channel c:
  - out_comb[c] = (enable & visible[c]) ? secret[c] : 0.
  - Zero latency, no register.
- Guard pipeline, per channel c, stages g[c][0..DEPTH-1]:
  - flush has priority: all stages <= 0 on that edge.
  - Otherwise g[c][0] <= (state == RELEASE_STATE) ? secret[c] : 0, sampling the pre-edge state.
  - Otherwise g[c][k] <= g[c][k-1] for k >= 1.
  - The capture decision does not depend on enable.
- Sequential output:
  - out_seq[c] = window ? g[c][DEPTH-1] : 0.
  - Combinational from registers.
  - Latency secret to out_seq is DEPTH cycles when the window aligns.
- Leak counter:
  - on each edge, if any out_seq channel is nonzero and leak_cnt < 2^CNT_W-1, increment.
  - Saturates at all ones and holds. Cleared only by reset.
  - flush does not clear leak_cnt.
- Reachability:
  - Leak via out_seq is possible only if some enable sequence makes prev == OBSERVE_PREV exactly DEPTH cycles after state == RELEASE_STATE.
  - With defaults (3, 1, DEPTH=1) this is impossible: prev==1 implies state==2, and the previous-cycle state was 1 or 2, never 3. Hence out_seq ≡ 0 and leak_cnt ≡ 0.
- Simultaneous events:
  - flush together with state == RELEASE_STATE: flush wins and stage 0 becomes 0.
  - enable low: state and prev hold, and the guard keeps recapturing while state == RELEASE_STATE.
- Reset asserted mid-operation: all registers clear immediately and asynchronously; outputs follow the reset values in the same cycle.
- No parameter combination may break the prev/state invariant.

Test Plan:
- Reset, then secret ch0 = 0xDEADBEEF, enable=1, visible=4'b0001 → out_comb ch0 = 0xDEADBEEF, other channels 0. Drop enable → out_comb all 0.
- Defaults, 1000 random cycles of enable/secret/visible with flush=0 → out_seq always 0, leak_cnt = 0, invariant prev == state-1 never violated.
- OBSERVE_PREV=3, DEPTH=1, enable held 1, secret ch2 = 0x12345678:
  - cycle with state==3 captures;
  - next cycle state=0, prev=3, window=1 → out_seq ch2 = 0x12345678;
  - leak_cnt increments by 1 per such cycle.
- Same configuration with flush asserted on the capture edge → out_seq stays 0 and leak_cnt unchanged.
- OBSERVE_PREV=0, DEPTH=2, enable=1 → secret sampled at state 3 appears on out_seq exactly 2 cycles later (prev=0). CNT_W=2 with repeated leaks → leak_cnt saturates at 3.
- Assert rst_n low mid-stream with guards nonzero → state=0, prev=3, out_seq=0, leak_cnt=0 before the next clock edge.
